// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the fetch PC, keeps one imem request in flight, queues PC-tagged words for decode (IFU_STALL_CNT_EN adds stall_cycles).
// Response-to-instr_valid is 1 cycle. Fetch parks in IDLE while the FIFO is full. A redirect flushes the FIFO and drops the in-flight word.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [31:0] stall_cycles
`endif
);

  localparam int            AW      = $clog2(FIFO_DEPTH);
  localparam int            CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;
  state_t state, state_next;

  logic [31:0]   fetch_pc;
  logic [31:0]   data_mem [FIFO_DEPTH];
  logic [31:0]   pc_mem   [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;
  logic          req_hs, push, pop;

  assign req_hs      = (state == REQ) && imem_req_ready;
  assign push        = (state == WAIT) && imem_rsp_valid && !redirect_valid;
  assign pop         = instr_valid && instr_ready && !redirect_valid;
  assign count_after = count + CW'(push) - CW'(pop);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (redirect_valid || (count < DEPTH_C)) state_next = REQ;
      end
      REQ: begin
        if (redirect_valid) state_next = req_hs ? DROP : REQ;
        else if (req_hs)    state_next = WAIT;
      end
      WAIT: begin
        if (redirect_valid)      state_next = imem_rsp_valid ? REQ : DROP;
        else if (imem_rsp_valid) state_next = (count_after < DEPTH_C) ? REQ : IDLE;
      end
      DROP: begin
        if (imem_rsp_valid) state_next = REQ;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    imem_req_valid = (state == REQ);
    imem_req_addr  = fetch_pc;
  end

  always_ff @(posedge clk) begin
    if (rst)                 fetch_pc <= RESET_PC;
    else if (redirect_valid) fetch_pc <= {redirect_pc[31:2], 2'b00};
    else if (req_hs)         fetch_pc <= fetch_pc + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst || redirect_valid) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_after;
    end
  end

  // In WAIT, fetch_pc has already stepped past the outstanding request.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_ptr] <= imem_rsp_data;
      pc_mem[wr_ptr]   <= fetch_pc - 32'd4;
    end
  end

  assign instr_valid = (count != '0);
  assign instr       = instr_valid ? data_mem[rd_ptr] : 32'd0;
  assign instr_pc    = instr_valid ? pc_mem[rd_ptr]   : 32'd0;

`ifdef IFU_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)                                      stall_cycles <= 32'd0;
    else if (!instr_valid && (stall_cycles != '1)) stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage upstream of the single-cycle MIPS datapath.
- Owns the fetch PC and issues word requests to a variable-latency instruction memory over a valid/ready request port and a valid response port.
- Buffers returned instructions, each tagged with its PC, in a small FIFO feeding decode.
- Accepts branch/jump redirects from the datapath: flushes buffered and in-flight instructions, then restarts fetch at the new PC.

Parameters:
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.
- FIFO_DEPTH, 2, instruction buffer entries; power of two, 2..8.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- redirect_valid  input  1  redirect fetch to redirect_pc this cycle.
- redirect_pc  input  32  redirect target; bits [1:0] ignored and forced to 0.
- imem_req_valid  output  1  request valid.
- imem_req_addr  output  32  word-aligned fetch address.
- imem_req_ready  input  1  memory accepts the request.
- imem_rsp_valid  input  1  response data valid, in order, one per accepted request.
- imem_rsp_data  input  32  fetched instruction.
- instr_valid  output  1  FIFO head valid.
- instr  output  32  FIFO head instruction.
- instr_pc  output  32  PC of the FIFO head.
- instr_ready  input  1  decode consumes the head.

Behaviour:
- One clock domain, clk. Reset is synchronous and active-high on rst.
- Reset values:
  - fetch_pc = RESET_PC; FIFO empty; FSM = IDLE.
  - imem_req_valid = 0; instr_valid = 0; instr = 0; instr_pc = 0 while empty.
- Reset asserted mid-transaction: the outstanding response is discarded. Any imem_rsp_valid arriving in the first cycle after reset is ignored.
- FSM states:
  - IDLE: no request. Go to REQ when count + 0 < FIFO_DEPTH, i.e. there is space for the returning word.
  - REQ: imem_req_valid = 1, imem_req_addr = fetch_pc. On handshake (valid & ready): fetch_pc += 4, wrapping mod 2^32, and go to WAIT.
  - WAIT: one request outstanding. On imem_rsp_valid, enqueue {data, pc_of_request}. Then go to REQ if count after enqueue < FIFO_DEPTH, else IDLE.
  - DROP: one stale request outstanding. On imem_rsp_valid, discard the data. Then go to REQ; the FIFO is empty after a flush.
- At most one request is outstanding. Fetch PC advances only on request handshake.
- Response-to-instr_valid latency: 1 cycle (enqueue registered). Best-case throughput: one instruction per 2 cycles with 1-cycle memory.
- FIFO:
  - Pop when instr_valid & instr_ready.
  - Push and pop in the same cycle are legal, including when full, in which case count is unchanged.
  - Outputs are driven directly from the head entry.
- Redirect (redirect_valid = 1), which has priority over every other event that cycle:
  - FIFO flushed; a pop that cycle is void.
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - IDLE or REQ without handshake: go to REQ next cycle with the new address. An imem_req_addr change while in REQ is permitted only on redirect.
  - REQ with handshake in the same cycle: go to DROP.
  - WAIT with no response this cycle: go to DROP.
  - WAIT with a response this cycle: discard the response, go to REQ.
  - DROP: stays DROP until the response arrives; the stale response is still pending.
  - Redirects in consecutive cycles: the last one wins.
- imem_rsp_valid in IDLE or REQ is a protocol error and is ignored.

Optional Feature:
- Macro IFU_STALL_CNT_EN.
- Defined:
  - Adds output stall_cycles, 32-bit.
  - Increments each cycle where instr_valid = 0 and rst = 0.
  - Saturates at 32'hFFFF_FFFF. Cleared by rst.
- Undefined: the port and the counter are absent. All other behaviour is identical.

Test Plan:
- Reset with RESET_PC = 32'h0000_0040, memory ready = 1, 1-cycle response, instr_ready = 1 -> first request addr 0x40. instr_valid delivers PCs 0x40, 0x44, 0x48 in order, one every 2 cycles.
- instr_ready = 0, FIFO_DEPTH = 2 -> exactly 2 words buffered (PCs 0x00, 0x04). imem_req_valid stays 0 in IDLE. Raising instr_ready resumes fetch at 0x08.
- Redirect to 32'h0000_0103 while in WAIT, response arriving 3 cycles later -> stale data dropped, FIFO empty. Next request addr 0x100. First delivered instr_pc = 0x100.
- Redirect in the same cycle as a pop and a response, with FIFO holding 1 entry -> FIFO empty next cycle, response discarded, next request addr equals the redirect target.
- fetch_pc = 32'hFFFF_FFFC handshake -> next request addr 32'h0000_0000.
- imem_req_ready held 0 for 5 cycles, then 1 -> imem_req_valid and imem_req_addr stable throughout. With IFU_STALL_CNT_EN defined, stall_cycles increases by the number of empty-FIFO cycles.
